// File: rtl/nano_risc_pkg.sv
// nano_risc_pkg: shared NanoRisc defaults and the data-memory controller state type
// Contents: DATA_WIDTH_DEF / ADDR_WIDTH_DEF default widths, mem_state_t {CLEAR, IDLE}.
package nano_risc_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  typedef enum logic {CLEAR, IDLE} mem_state_t;
endpackage

// File: rtl/data_memory_sync_if.sv
// data_memory_sync_if: request/response bundle between load/store stage and data memory
// Requests: clear, MemRead, MemWrite, address, writeData (master drives).
// Responses: ready, busy, dataOut, readValid, rangeError, parityError (slave drives).
interface data_memory_sync_if import nano_risc_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  clear;
  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  ready;
  logic                  busy;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  readValid;
  logic                  rangeError;
  logic                  parityError;
  modport master (
    output clear, MemRead, MemWrite, address, writeData,
    input  ready, busy, dataOut, readValid, rangeError, parityError
  );
  modport slave (
    input  clear, MemRead, MemWrite, address, writeData,
    output ready, busy, dataOut, readValid, rangeError, parityError
  );
endinterface

// File: rtl/data_memory_clear_fsm.sv
// data_memory_clear_fsm: CLEAR/IDLE sequencer that walks a zeroing pointer over the array
// Ports: clock, resetN (async active-low), clear (restart pulse), ready/busy status,
//        clr_we/clr_ptr (zero-write strobe and word index for the array).
module data_memory_clear_fsm import nano_risc_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  clear,
  output logic                  ready,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_ptr
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  mem_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  always_comb begin
    state_d = clear ? CLEAR : (state_q == CLEAR && ptr_q == LAST) ? IDLE : state_q;
    ptr_d   = (clear || state_q == IDLE || ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  assign ready   = state_q == IDLE;
  assign busy    = state_q == CLEAR;
  assign clr_we  = busy;
  assign clr_ptr = ptr_q;
endmodule

// File: rtl/data_memory_sync.sv
// data_memory_sync: self-clearing synchronous-read word RAM with 1-cycle registered read and valid pulse
// Ports: clock, resetN (async active-low), bus (data_memory_sync_if.slave).
// Build option: define DATA_MEMORY_PARITY_EN to store an even-parity bit per word and flag mismatches.
module data_memory_sync import nano_risc_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 16
) (
  input logic clock,
  input logic resetN,
  data_memory_sync_if.slave bus
);
`ifdef DATA_MEMORY_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW = DATA_WIDTH + PW;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  logic [MW-1:0]         mem_q [DEPTH];
  logic [MW-1:0]         wr_word, rd_word;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  ready, clr_we, in_range, acc, rd, wr;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  read_valid_q, read_valid_d;
  logic                  range_error_q, range_error_d;
  logic                  parity_error_q, parity_error_d;
  data_memory_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_fsm (
    .clock   (clock),
    .resetN  (resetN),
    .clear   (bus.clear),
    .ready   (ready),
    .busy    (bus.busy),
    .clr_we  (clr_we),
    .clr_ptr (clr_ptr)
  );
  // a request arriving with clear is dropped, so clear masks acceptance
  always_comb begin
    in_range = {1'b0, bus.address} < DEPTH_W;
    acc      = ready & ~bus.clear;
    rd       = acc & bus.MemRead;
    wr       = acc & bus.MemWrite & in_range;
    rd_word  = mem_q[bus.address];
`ifdef DATA_MEMORY_PARITY_EN
    wr_word        = {^bus.writeData, bus.writeData};
    parity_error_d = rd & in_range & ~bus.MemWrite & (^rd_word);
`else
    wr_word        = bus.writeData;
    parity_error_d = 1'b0;
`endif
    // write-first: a same-cycle write is forwarded to the read data
    data_out_d    = !rd ? data_out_q : !in_range ? '0 : bus.MemWrite ? bus.writeData : rd_word[DATA_WIDTH-1:0];
    read_valid_d  = rd;
    range_error_d = acc & (bus.MemRead | bus.MemWrite) & ~in_range;
  end
  always_ff @(posedge clock) begin
    if (clr_we) mem_q[clr_ptr] <= '0;
    else if (wr) mem_q[bus.address] <= wr_word;
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      data_out_q     <= '0;
      read_valid_q   <= 1'b0;
      range_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
    end else begin
      data_out_q     <= data_out_d;
      read_valid_q   <= read_valid_d;
      range_error_q  <= range_error_d;
      parity_error_q <= parity_error_d;
    end
  end
  assign bus.ready       = ready;
  assign bus.dataOut     = data_out_q;
  assign bus.readValid   = read_valid_q;
  assign bus.rangeError  = range_error_q;
  assign bus.parityError = parity_error_q;
endmodule

// File: tb/tb_data_memory_sync.sv
// tb_data_memory_sync: randomized scoreboard bench driving a DEPTH=16 and a DEPTH=12 memory in lockstep
module tb_data_memory_sync;
`ifdef DATA_MEMORY_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef struct packed {
    logic       rv;
    logic       re;
    logic       pe;
    logic [7:0] data;
  } exp_t;
  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       clear = 1'b0;
  logic       mem_read = 1'b0;
  logic       mem_write = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] write_data = '0;
  bit         flip_req = 1'b0;
  int         checks = 0;
  int         errors = 0;
  always #5 clock = ~clock;
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int D = (g == 0) ? 16 : 12;
    data_memory_sync_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
    assign bus.clear     = clear;
    assign bus.MemRead   = mem_read;
    assign bus.MemWrite  = mem_write;
    assign bus.address   = address;
    assign bus.writeData = write_data;
    data_memory_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(D)) dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus)
    );
    logic [7:0] m [16];
    bit         bad [16];
    int         busy_cnt = D;
    logic [7:0] dout = '0;
    exp_t       q[$];
    exp_t       e;
    // reference: busy_cnt counts remaining clear cycles; contents zeroed when a clear starts
    always @(posedge clock or negedge resetN) begin
      automatic bit ok = int'(address) < D;
      automatic logic [7:0] v = !ok ? 8'h00 : mem_write ? write_data : m[address];
      if (!resetN) begin
        busy_cnt <= D;
        dout <= '0;
        q.delete();
        for (int i = 0; i < 16; i++) begin m[i] <= '0; bad[i] <= 1'b0; end
      end else if (clear) begin
        busy_cnt <= D;
        for (int i = 0; i < 16; i++) begin m[i] <= '0; bad[i] <= 1'b0; end
      end else if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
      end else begin
        if (flip_req && g == 0) bad[5] <= 1'b1;
        if (mem_write && ok) begin m[address] <= write_data; bad[address] <= 1'b0; end
        if (mem_read) begin
          dout <= v;
          q.push_back(exp_t'({1'b1, !ok, ok && !mem_write && bad[address] && PAR, v}));
        end else if (mem_write && !ok) begin
          q.push_back(exp_t'({1'b0, 1'b1, 1'b0, dout}));
        end
      end
    end
    always begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.ready !== (busy_cnt == 0) || bus.busy !== (busy_cnt != 0)) begin
        errors++;
        $display("FAIL ready_busy D=%0d t=%0t: got ready=%b busy=%b, want ready=%b", D, $time, bus.ready, bus.busy, busy_cnt == 0);
      end
      if (bus.readValid || bus.rangeError || bus.parityError) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out D=%0d t=%0t: got rv=%b re=%b pe=%b data=%h, want none", D, $time, bus.readValid, bus.rangeError, bus.parityError, bus.dataOut);
        end else begin
          e = q.pop_front();
          if ({bus.readValid, bus.rangeError, bus.parityError, bus.dataOut} !== e) begin
            errors++;
            $display("FAIL response D=%0d t=%0t: got rv=%b re=%b pe=%b data=%h, want rv=%b re=%b pe=%b data=%h", D, $time, bus.readValid, bus.rangeError, bus.parityError, bus.dataOut, e.rv, e.re, e.pe, e.data);
          end
        end
      end
    end
  end
  task automatic op(input bit r, input bit w, input logic [3:0] a, input logic [7:0] d);
    @(negedge clock);
    mem_read = r;
    mem_write = w;
    address = a;
    write_data = d;
  endtask
  task automatic idle();
    @(negedge clock);
    clear = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask
  task automatic wait_ready(input int e0, input int e1);
    int n = 0;
    int n0 = -1;
    int n1 = -1;
    while ((n0 < 0 || n1 < 0) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
      if (n0 < 0 && inst[0].bus.ready) n0 = n;
      if (n1 < 0 && inst[1].bus.ready) n1 = n;
    end
    checks++;
    if (n0 < 0 || n1 < 0) begin
      errors++;
      $display("FAIL ready_timeout: got n0=%0d n1=%0d, want both ready within 200 cycles", n0, n1);
    end
    if (e0 >= 0) begin
      checks++;
      if (n0 != e0 || n1 != e1) begin
        errors++;
        $display("FAIL busy_cycles: got %0d/%0d, want %0d/%0d", n0, n1, e0, e1);
      end
    end
    @(negedge clock);
  endtask
  task automatic read_all();
    for (int a = 0; a < 16; a++) op(1'b1, 1'b0, 4'(a), 8'h00);
    idle();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    wait_ready(16, 12);
    read_all();
    op(1'b0, 1'b1, 4'd10, 8'd22);
    op(1'b1, 1'b0, 4'd10, 8'h00);
    idle();
    op(1'b1, 1'b1, 4'd3, 8'h5A);
    idle();
    op(1'b1, 1'b0, 4'd3, 8'h00);
    op(1'b1, 1'b0, 4'd13, 8'h00);
    op(1'b0, 1'b1, 4'd13, 8'hEE);
    read_all();
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      clear = ($urandom_range(49) == 0);
      mem_read = 1'($urandom_range(1));
      mem_write = ($urandom_range(2) == 0);
      address = 4'($urandom_range(15));
      write_data = 8'($urandom);
    end
    idle();
    wait_ready(-1, -1);
    for (int a = 0; a < 16; a++) op(1'b0, 1'b1, 4'(a), 8'(a * 7 + 1));
    @(negedge clock);
    clear = 1'b1;
    mem_write = 1'b1;
    address = 4'd4;
    write_data = 8'd77;
    @(negedge clock);
    clear = 1'b0;
    mem_write = 1'b0;
    @(negedge clock);
    mem_write = 1'b1;
    mem_read = 1'b1;
    idle();
    wait_ready(-1, -1);
    read_all();
    @(negedge clock);
    clear = 1'b1;
    idle();
    repeat (6) @(negedge clock);
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    wait_ready(16, 12);
    op(1'b0, 1'b1, 4'd5, 8'h3C);
    op(1'b1, 1'b0, 4'd5, 8'h00);
    idle();
`ifdef DATA_MEMORY_PARITY_EN
    flip_req = 1'b1;
    inst[0].dut.mem_q[5][8] <= ~inst[0].dut.mem_q[5][8];
    @(negedge clock);
    flip_req = 1'b0;
    op(1'b1, 1'b0, 4'd5, 8'h00);
    idle();
`endif
    repeat (3) @(negedge clock);
    checks++;
    if (inst[0].q.size() != 0 || inst[1].q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: got %0d/%0d left, want 0/0", inst[0].q.size(), inst[1].q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
